// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier: run-time loadable node table, one node per clock.
// Node word = {is_leaf, feat_idx, prec, thr, left, right}; node 0 is the root.
module dtree_seq_engine #(
  parameter int N_FEAT    = 5,
  parameter int FEAT_W    = 8,
  parameter int N_NODES   = 64,
  parameter int MAX_DEPTH = 16,
  parameter int CLASS_W   = 1,
  localparam int FI_W     = $clog2(N_FEAT),
  localparam int PW       = $clog2(FEAT_W),
  localparam int NP_W     = $clog2(N_NODES),
  localparam int NODE_W   = 1 + FI_W + PW + FEAT_W + 2 * NP_W,
  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [NP_W-1:0]          cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  output logic                     cfg_ack,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  output logic [DEPTH_W-1:0]       out_depth
);

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [NODE_W-1:0]   node_tbl_r [N_NODES];
  logic [FEAT_W-1:0]   feat_r [N_FEAT];
  logic [NP_W-1:0]     ptr_r, ptr_s;
  logic [DEPTH_W-1:0]  depth_r, depth_s;
  logic                valid_s, err_s, ready_s;
  logic [CLASS_W-1:0]  class_s;
  logic [DEPTH_W-1:0]  out_depth_s;

  logic [NODE_W-1:0]   node_s;
  logic                node_leaf_s;
  logic [FI_W-1:0]     node_fi_s;
  logic [PW-1:0]       node_prec_s;
  logic [FEAT_W-1:0]   node_thr_s;
  logic [NP_W-1:0]     node_left_s, node_right_s, next_ptr_s;
  logic [FEAT_W-1:0]   feat_sel_s, feat_shr_s;
  logic [PW-1:0]       shamt_s;
  logic                accept_s, fault_s;

  assign node_s       = node_tbl_r[ptr_r];
  assign node_leaf_s  = node_s[NODE_W-1];
  assign node_fi_s    = node_s[NODE_W-2 -: FI_W];
  assign node_prec_s  = node_s[NODE_W-2-FI_W -: PW];
  assign node_thr_s   = node_s[2*NP_W +: FEAT_W];
  assign node_left_s  = node_s[NP_W +: NP_W];
  assign node_right_s = node_s[0 +: NP_W];

  assign accept_s = in_valid && in_ready;
  assign cfg_ack  = cfg_we && (state_r == IDLE);

  // Feature mux and precision-reduced compare: only the top prec+1 bits meet the threshold.
  always_comb begin
    feat_sel_s = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      feat_sel_s = (node_fi_s == FI_W'(i)) ? feat_r[i] : feat_sel_s;
    end
    shamt_s    = PW'(FEAT_W - 1) - node_prec_s;
    feat_shr_s = feat_sel_s >> shamt_s;
    next_ptr_s = (feat_shr_s <= node_thr_s) ? node_left_s : node_right_s;
    fault_s    = (depth_r == DEPTH_W'(MAX_DEPTH))
              || ({1'b0, node_fi_s} >= (FI_W + 1)'(N_FEAT))
              || ({1'b0, next_ptr_s} >= (NP_W + 1)'(N_NODES));
  end

  // Next-state and result logic.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    depth_s     = depth_r;
    valid_s     = out_valid;
    class_s     = out_class;
    err_s       = out_err;
    out_depth_s = out_depth;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EVAL;
          ptr_s   = '0;
          depth_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      EVAL: begin
        if (node_leaf_s) begin
          state_s     = DONE;
          valid_s     = 1'b1;
          class_s     = node_thr_s[CLASS_W-1:0];
          err_s       = 1'b0;
          out_depth_s = depth_r;
        end else if (fault_s) begin
          state_s     = DONE;
          valid_s     = 1'b1;
          class_s     = '0;
          err_s       = 1'b1;
          out_depth_s = depth_r;
        end else begin
          ptr_s   = next_ptr_s;
          depth_s = depth_r + DEPTH_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
          valid_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
    ready_s = (state_s == IDLE);
  end

  // FSM, traversal and output registers; features latched on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      depth_r   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_err   <= 1'b0;
      out_depth <= '0;
      for (int i = 0; i < N_FEAT; i++) feat_r[i] <= '0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      depth_r   <= depth_s;
      in_ready  <= ready_s;
      out_valid <= valid_s;
      out_class <= class_s;
      out_err   <= err_s;
      out_depth <= out_depth_s;
      if (accept_s) begin
        for (int i = 0; i < N_FEAT; i++) feat_r[i] <= in_feat[i*FEAT_W +: FEAT_W];
      end else begin
        for (int i = 0; i < N_FEAT; i++) feat_r[i] <= feat_r[i];
      end
    end
  end

  // Node table: writable only while idle, so a traversal never sees a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) node_tbl_r[i] <= '0;
    end else if (cfg_ack) begin
      node_tbl_r[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Directed bench for dtree_seq_engine: hand-built trees with hand-computed classes and latencies.
module tb_dtree_seq_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [26:0] cfg_data;
  logic        cfg_ack;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_feat;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_class;
  logic        out_err;
  logic [4:0]  out_depth;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  dtree_seq_engine dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .out_depth(out_depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] mk_node(input logic leaf, input logic [2:0] fi,
                                          input logic [2:0] prec, input logic [7:0] thr,
                                          input logic [5:0] l, input logic [5:0] r);
    return {leaf, fi, prec, thr, l, r};
  endfunction

  task automatic cfg(input logic [5:0] addr, input logic [26:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    #1 chk("cfg_ack_idle", cfg_ack, 1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic start(input logic [39:0] f);
    in_feat = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int c0, output int c);
    c = c0;
    while (out_valid !== 1'b1 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_hs", out_valid, 0);
    chk("ready_after_hs", in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [39:0] f, input int e_cls,
                     input int e_err, input int e_dep);
    int c;
    chk({tag, "_in_ready"}, in_ready, 1);
    start(f);
    wait_res(1, c);
    chk({tag, "_latency"}, c, 2 + e_dep);
    chk({tag, "_class"}, out_class, e_cls);
    chk({tag, "_err"}, out_err, e_err);
    chk({tag, "_depth"}, out_depth, e_dep);
    consume();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_depth", out_depth, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // zeroed table: root loops to itself until the depth limit
    run("zero_tbl", 40'h00_00_00_00_55, 0, 1, 16);

    // single leaf root
    cfg(6'd0, mk_node(1'b1, 3'd0, 3'd0, 8'h01, 6'd0, 6'd0));
    run("root_leaf", 40'h0, 1, 0, 0);

    // root compares top 2 bits of X0 against 0
    cfg(6'd1, mk_node(1'b1, 3'd0, 3'd0, 8'h00, 6'd0, 6'd0));
    cfg(6'd2, mk_node(1'b1, 3'd0, 3'd0, 8'h01, 6'd0, 6'd0));
    cfg(6'd0, mk_node(1'b0, 3'd0, 3'd1, 8'h00, 6'd1, 6'd2));
    run("x0_3f", 40'h00_00_00_00_3F, 0, 0, 1);
    run("x0_40", 40'h00_00_00_00_40, 1, 0, 1);

    // backpressure: result held five cycles
    start(40'h00_00_00_00_3F);
    wait_res(1, cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_class", out_class, 0);
      chk("hold_depth", out_depth, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    consume();

    // config writes dropped during EVAL and DONE
    start(40'h00_00_00_00_40);
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = mk_node(1'b1, 3'd0, 3'd0, 8'h00, 6'd0, 6'd0);
    #1 chk("cfg_ack_eval", cfg_ack, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    wait_res(2, cyc);
    chk("cfg_eval_latency", cyc, 3);
    chk("cfg_eval_class", out_class, 1);
    cfg_we = 1'b1;
    #1 chk("cfg_ack_done", cfg_ack, 0);
    cfg_we = 1'b0;
    consume();
    run("after_drop", 40'h00_00_00_00_40, 1, 0, 1);

    // write and accept in the same IDLE cycle: traversal sees the new root
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = mk_node(1'b1, 3'd0, 3'd0, 8'h00, 6'd0, 6'd0);
    in_valid = 1'b1; in_feat = 40'h00_00_00_00_40;
    #1 chk("cfg_ack_with_in", cfg_ack, 1);
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_res(1, cyc);
    chk("same_cyc_latency", cyc, 2);
    chk("same_cyc_class", out_class, 0);
    chk("same_cyc_depth", out_depth, 0);
    consume();

    // two-level tree on X4 (full precision) then X1 (top 4 bits)
    cfg(6'd3, mk_node(1'b0, 3'd1, 3'd3, 8'h05, 6'd1, 6'd2));
    cfg(6'd0, mk_node(1'b0, 3'd4, 3'd7, 8'h80, 6'd3, 6'd2));
    run("deep_left", 40'h80_00_00_5A_00, 0, 0, 2);
    run("deep_right", 40'h80_00_00_60_00, 1, 0, 2);
    run("x4_over", 40'h81_00_00_00_00, 1, 0, 1);

    // feature index out of range
    cfg(6'd0, mk_node(1'b0, 3'd5, 3'd0, 8'h00, 6'd1, 6'd1));
    run("feat_fault", 40'hFF_FF_FF_FF_FF, 0, 1, 0);

    // reset two cycles into a depth-2 traversal
    cfg(6'd4, mk_node(1'b0, 3'd0, 3'd0, 8'hFF, 6'd2, 6'd2));
    cfg(6'd0, mk_node(1'b0, 3'd0, 3'd0, 8'hFF, 6'd4, 6'd4));
    start(40'h00_00_00_00_12);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("midrst_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_valid_after", out_valid, 0);
    run("midrst_zero_tbl", 40'h00_00_00_00_12, 0, 1, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
